btn_stepper: RTL

BTN_STEPPER -- requirements
Module: btn_stepper

---
 rtl/btn_stepper.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/btn_stepper.sv
// Two-button track stepper: synchronise, debounce, then a press FSM that emits inc/dec pulses.
// Define BTN_STEPPER_AUTO_REPEAT_EN to enable hold-to-repeat (DELAY/REPEAT states).
module btn_stepper #(
  parameter int DEBOUNCE_CYC     = 500000,
  parameter int REPEAT_DELAY_CYC = 25000000,
  parameter int REPEAT_RATE_CYC  = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  output logic inc,
  output logic dec,
  output logic ena,
  output logic held
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  if (DEBOUNCE_CYC < 2 || REPEAT_DELAY_CYC < 2 || REPEAT_RATE_CYC < 2) begin : g_bad_cfg
    $error("btn_stepper: all cycle parameters must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_DELAY,
    S_REPEAT,
    S_RELEASE
  } state_t;

  // Bit 0 carries btn_up, bit 1 carries btn_down throughout.
  logic [1:0]      sync1_q, sync1_d;
  logic [1:0]      sync2_q, sync2_d;
  logic [1:0]      deb_q, deb_d;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];

  state_t state_q, state_d;
  logic   dir_q, dir_d;
  logic   inc_q, inc_d;
  logic   dec_q, dec_d;
  logic   ena_q, ena_d;
  logic   held_q, held_d;
  logic   pulse;
  logic   lat_now, opp_now;

`ifdef BTN_STEPPER_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                                 : REPEAT_RATE_CYC;
  localparam int              RPT_W     = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] RPT_DELAY = RPT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [RPT_W-1:0] RPT_RATE  = RPT_W'(REPEAT_RATE_CYC - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  assign sync1_d = {btn_down, btn_up};
  assign sync2_d = sync1_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Abort conditions look at the level being accepted this cycle, so a change
  // that lands on a pulse cycle already suppresses that pulse.
  assign lat_now = deb_d[dir_q];
  assign opp_now = deb_d[~dir_q];

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pulse   = 1'b0;
`ifdef BTN_STEPPER_AUTO_REPEAT_EN
    rpt_d   = rpt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (deb_q[0] ^ deb_q[1]) begin
          state_d = S_PRESS;
          dir_d   = deb_q[1];
        end
      end
      S_PRESS: begin
        if (!lat_now) begin
          state_d = S_IDLE;
        end else if (opp_now) begin
          state_d = S_RELEASE;
        end else begin
          pulse = 1'b1;
`ifdef BTN_STEPPER_AUTO_REPEAT_EN
          state_d = S_DELAY;
          rpt_d   = RPT_DELAY;
`else
          state_d = S_RELEASE;
`endif
        end
      end
`ifdef BTN_STEPPER_AUTO_REPEAT_EN
      S_DELAY, S_REPEAT: begin
        if (!lat_now) begin
          state_d = S_IDLE;
        end else if (opp_now) begin
          state_d = S_RELEASE;
        end else if (rpt_q == '0) begin
          // Reload on the pulse cycle itself so the period never drifts.
          pulse   = 1'b1;
          state_d = S_REPEAT;
          rpt_d   = RPT_RATE;
        end else begin
          rpt_d = rpt_q - 1'b1;
        end
      end
`endif
      S_RELEASE: begin
        if (deb_q == 2'b00) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign inc_d  = pulse & ~dir_q;
  assign dec_d  = pulse & dir_q;
  assign ena_d  = pulse;
  assign held_d = (state_q == S_PRESS) || (state_q == S_DELAY) || (state_q == S_REPEAT);

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      ena_q       <= 1'b0;
      held_q      <= 1'b0;
`ifdef BTN_STEPPER_AUTO_REPEAT_EN
      rpt_q       <= '0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      state_q     <= state_d;
      dir_q       <= dir_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      ena_q       <= ena_d;
      held_q      <= held_d;
`ifdef BTN_STEPPER_AUTO_REPEAT_EN
      rpt_q       <= rpt_d;
`endif
    end
  end

  assign inc  = inc_q;
  assign dec  = dec_q;
  assign ena  = ena_q;
  assign held = held_q;

endmodule
